uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 157 +++++++++++++++
 tb/tb_uart_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter fed from a first-word-fall-through TX FIFO.
// Each bit lasts 16 baud pulses; frame format is latched when a byte is popped.
module uart_tx (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_pulse,
   input  logic [7:0] tx_fifo_dout,
   input  logic       tx_fifo_empty,
   output logic       tx_fifo_pop,
   input  logic [1:0] wls,
   input  logic       stb,
   input  logic       pen,
   input  logic       eps,
   input  logic       sticky_parity,
   input  logic       set_break,
   output logic       tx_out,
   output logic       tx_busy,
   output logic       tx_temt
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t     state_q, state_d;
   logic [3:0] tick_q, tick_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] data_q;
   logic [1:0] wls_q;
   logic       stb_q, pen_q, eps_q, sticky_q;
   logic       load;
   logic       stop_end;
   logic       parity_bit;
   logic       tx_out_d;
   logic [7:0] data_mask;
   logic [2:0] last_bit;

   assign last_bit = 3'd4 + {1'b0, wls_q};

   always_comb begin
      case (wls_q)
         2'b00:   data_mask = 8'h1F;
         2'b01:   data_mask = 8'h3F;
         2'b10:   data_mask = 8'h7F;
         default: data_mask = 8'hFF;
      endcase
   end

   assign parity_bit = sticky_q ? ~eps_q
                     : (eps_q ? ^(data_q & data_mask) : ~^(data_q & data_mask));

   // Two stop bits are split into two 16-pulse halves tracked by bit_cnt;
   // the 1.5-stop case ends the second half at tick 7.
   assign stop_end = stb_q ? (bit_cnt_q[0] && (tick_q == ((wls_q == 2'b00) ? 4'd7 : 4'd15)))
                           : (tick_q == 4'd15);

   // NOTE: every signal written here gets a default first, so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_cnt_d = bit_cnt_q;
      load      = 1'b0;
      if (baud_pulse) begin
         tick_d = tick_q + 4'd1;
         case (state_q)
            IDLE: begin
               tick_d = 4'd0;
               if (!tx_fifo_empty) begin
                  state_d = START;
                  load    = 1'b1;
               end
            end
            START: begin
               if (tick_q == 4'd15) begin
                  state_d   = DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            DATA: begin
               if (tick_q == 4'd15) begin
                  if (bit_cnt_q == last_bit) begin
                     state_d   = pen_q ? PARITY : STOP;
                     bit_cnt_d = 3'd0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end
            end
            PARITY: begin
               if (tick_q == 4'd15) state_d = STOP;
            end
            STOP: begin
               if (stop_end) begin
                  tick_d    = 4'd0;
                  bit_cnt_d = 3'd0;
                  if (!tx_fifo_empty) begin
                     state_d = START;
                     load    = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else if (tick_q == 4'd15) begin
                  bit_cnt_d = 3'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      case (state_d)
         START:   tx_out_d = 1'b0;
         DATA:    tx_out_d = data_q[bit_cnt_d];
         PARITY:  tx_out_d = parity_bit;
         default: tx_out_d = 1'b1;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         tick_q    <= 4'd0;
         bit_cnt_q <= 3'd0;
         tx_out    <= 1'b1;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_cnt_q <= bit_cnt_d;
         tx_out    <= set_break ? 1'b0 : tx_out_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q   <= 8'h00;
         wls_q    <= 2'b00;
         stb_q    <= 1'b0;
         pen_q    <= 1'b0;
         eps_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else if (load) begin
         data_q   <= tx_fifo_dout;
         wls_q    <= wls;
         stb_q    <= stb;
         pen_q    <= pen;
         eps_q    <= eps;
         sticky_q <= sticky_parity;
      end
   end

   assign tx_fifo_pop = load & ~rst;
   assign tx_busy     = (state_q != IDLE);
   assign tx_temt     = ~tx_busy & tx_fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed checks of uart_tx against a pulse-level
// model that expands each popped byte into its expected line levels.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       baud_pulse = 1'b0;
   logic [7:0] tx_fifo_dout;
   logic       tx_fifo_empty;
   logic       tx_fifo_pop;
   logic [1:0] wls;
   logic       stb, pen, eps, sticky_parity, set_break;
   logic       tx_out, tx_busy, tx_temt;

   int         n_checks = 0;
   int         n_errors = 0;
   int         baud_mode = 0;    // 0: every cycle, 1: random, 2: frozen
   int         rd_ptr = 0;
   int         wr_ptr = 0;
   logic [7:0] fifo_mem [64];
   bit         exp_q [$];        // expected line level, one entry per baud pulse
   logic       brk_prev = 1'b0;

   uart_tx dut (
      .clk          (clk),
      .rst          (rst),
      .baud_pulse   (baud_pulse),
      .tx_fifo_dout (tx_fifo_dout),
      .tx_fifo_empty(tx_fifo_empty),
      .tx_fifo_pop  (tx_fifo_pop),
      .wls          (wls),
      .stb          (stb),
      .pen          (pen),
      .eps          (eps),
      .sticky_parity(sticky_parity),
      .set_break    (set_break),
      .tx_out       (tx_out),
      .tx_busy      (tx_busy),
      .tx_temt      (tx_temt)
   );

   always #5 clk = ~clk;

   assign tx_fifo_dout  = fifo_mem[rd_ptr[5:0]];
   assign tx_fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) if (tx_fifo_pop) rd_ptr <= rd_ptr + 1;

   always @(posedge clk) begin
      #1;
      case (baud_mode)
         0:       baud_pulse = 1'b1;
         1:       baud_pulse = ($urandom_range(0, 1) == 0);
         default: baud_pulse = 1'b0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         if (n_errors <= 30) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void push_level(input bit lvl, input int pulses);
      for (int i = 0; i < pulses; i++) exp_q.push_back(lvl);
   endfunction

   function automatic void build_frame(input logic [7:0] d, input logic [1:0] w, input logic s,
                                       input logic p, input logic e, input logic k);
      int nbits = 5 + int'(w);
      int ones  = 0;
      push_level(1'b0, 16);
      for (int i = 0; i < nbits; i++) begin
         push_level(d[i], 16);
         ones += int'(d[i]);
      end
      if (p) push_level(k ? ~e : (e ? bit'(ones % 2) : ~bit'(ones % 2)), 16);
      push_level(1'b1, !s ? 16 : (w == 2'b00 ? 24 : 32));
   endfunction

   always @(negedge clk) begin
      logic lvl, exp_pop;
      if (!rst) begin
         lvl = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
         check("tx_out", tx_out, brk_prev ? 1'b0 : lvl);
         check("tx_busy", tx_busy, exp_q.size() != 0);
         check("tx_temt", tx_temt, (exp_q.size() == 0) && tx_fifo_empty);
         if (baud_pulse && exp_q.size() != 0) void'(exp_q.pop_front());
         exp_pop = baud_pulse && !tx_fifo_empty && (exp_q.size() == 0);
         check("tx_fifo_pop", tx_fifo_pop, exp_pop);
         if (exp_pop) build_frame(tx_fifo_dout, wls, stb, pen, eps, sticky_parity);
      end
      brk_prev = set_break;
   end

   task automatic push(input logic [7:0] b);
      fifo_mem[wr_ptr[5:0]] = b;
      wr_ptr++;
   endtask

   task automatic wait_pop(output logic seen);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (tx_fifo_pop) seen = 1'b1;
      end
   endtask

   // Starting at the pop negedge, sample each bit mid-way (baud every cycle).
   task automatic sample_frame(input int nbits, input int total, output logic [15:0] bits,
                               output logic all_busy, output logic pop_at_end);
      bits = '0; all_busy = 1'b1; pop_at_end = 1'b0;
      for (int n = 1; n <= total; n++) begin
         @(negedge clk);
         if (!tx_busy) all_busy = 1'b0;
         if ((n % 16) == 8 && (n / 16) < nbits) bits[n / 16] = tx_out;
         if (n == total) pop_at_end = tx_fifo_pop;
      end
   endtask

   task automatic directed(input string tag, input logic [7:0] b, input logic [1:0] w,
                           input logic s, input logic p, input logic e, input logic k,
                           input int nbits, input int total, input logic [15:0] exp_bits);
      logic seen, all_busy, pe;
      logic [15:0] bits;
      int p0;
      @(posedge clk); #1;
      wls = w; stb = s; pen = p; eps = e; sticky_parity = k;
      p0 = rd_ptr;
      push(b);
      wait_pop(seen);
      check({tag, "_pop_seen"}, seen, 1'b1);
      sample_frame(nbits, total, bits, all_busy, pe);
      check({tag, "_bits"}, bits, exp_bits);
      check({tag, "_busy_thru"}, all_busy, 1'b1);
      @(negedge clk);
      check({tag, "_busy_fall"}, tx_busy, 1'b0);
      check({tag, "_pops"}, rd_ptr - p0, 1);
   endtask

   task automatic drain(input string tag);
      logic done = 1'b0;
      for (int i = 0; i < 20000 && !done; i++) begin
         @(posedge clk);
         if (rd_ptr == wr_ptr && !tx_busy) done = 1'b1;
      end
      check(tag, done, 1'b1);
   endtask

   initial begin
      logic seen, all_busy, pe, hold;
      logic [15:0] bits;
      int p0;
      rst = 1'b0; wls = 2'b11; stb = 1'b0; pen = 1'b0; eps = 1'b0;
      sticky_parity = 1'b0; set_break = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("rst_tx_out", tx_out, 1'b1);
      check("rst_busy", tx_busy, 1'b0);
      check("rst_pop", tx_fifo_pop, 1'b0);
      check("rst_temt", tx_temt, 1'b1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      directed("a5_8n1", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 10, 160, 16'b1101001010);
      directed("53_7e1", 8'h53, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 10, 160, 16'b1010100110);
      directed("53_7o1", 8'h53, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 10, 160, 16'b1110100110);
      directed("1f_5s15", 8'h1F, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 8, 136, 16'b11111110);

      // Back-to-back frames: the second pop lands on the last stop pulse.
      @(posedge clk); #1;
      wls = 2'b11; stb = 1'b0; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0;
      p0 = rd_ptr;
      push(8'h00);
      push(8'hFF);
      wait_pop(seen);
      check("b2b_pop1", seen, 1'b1);
      sample_frame(10, 160, bits, all_busy, pe);
      check("b2b_bits1", bits, 16'b1000000000);
      check("b2b_busy1", all_busy, 1'b1);
      check("b2b_pop2", pe, 1'b1);
      sample_frame(10, 160, bits, all_busy, pe);
      check("b2b_bits2", bits, 16'b1111111110);
      check("b2b_busy2", all_busy, 1'b1);
      @(negedge clk);
      check("b2b_busy_fall", tx_busy, 1'b0);
      check("b2b_pops", rd_ptr - p0, 2);

      // Break during DATA of 0xFF; the frame timing must be unaffected.
      @(posedge clk); #1;
      p0 = rd_ptr;
      push(8'hFF);
      wait_pop(seen);
      check("brk_pop", seen, 1'b1);
      repeat (30) @(negedge clk);
      @(posedge clk); #1 set_break = 1'b1;
      repeat (2) @(negedge clk);
      check("brk_low", tx_out, 1'b0);
      repeat (20) @(negedge clk);
      @(posedge clk); #1 set_break = 1'b0;
      repeat (2) @(negedge clk);
      check("brk_release", tx_out, 1'b1);
      repeat (160 - 54) @(negedge clk);
      check("brk_busy_end", tx_busy, 1'b1);
      @(negedge clk);
      check("brk_busy_fall", tx_busy, 1'b0);
      check("brk_pops", rd_ptr - p0, 1);

      // Random phase: sparse baud pulses, mid-frame config and break changes.
      @(posedge clk); #1 baud_mode = 1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         wls = 2'($urandom); stb = 1'($urandom); pen = 1'($urandom);
         eps = 1'($urandom); sticky_parity = 1'($urandom);
         set_break = ($urandom_range(0, 7) == 0);
         push(8'($urandom));
         if ($urandom_range(0, 1) == 1) push(8'($urandom));
         repeat ($urandom_range(50, 400)) @(posedge clk);
      end
      #1 set_break = 1'b0;
      drain("rand_drain");

      // Freeze: no baud pulses for a long stretch mid-frame.
      @(posedge clk); #1;
      p0 = rd_ptr;
      push(8'h96);
      wait_pop(seen);
      check("frz_pop", seen, 1'b1);
      repeat (30) @(negedge clk);
      @(posedge clk); #1 baud_mode = 2;
      repeat (2) @(negedge clk);
      hold = tx_out;
      repeat (60) @(negedge clk);
      check("frz_hold", tx_out, hold);
      check("frz_busy", tx_busy, 1'b1);
      check("frz_pops", rd_ptr - p0, 1);
      @(posedge clk); #1 baud_mode = 1;
      drain("frz_drain");

      // Reset in the middle of DATA aborts the frame.
      @(posedge clk); #1;
      baud_mode = 0; wls = 2'b11; stb = 1'b0; pen = 1'b0;
      p0 = rd_ptr;
      push(8'h5A);
      wait_pop(seen);
      check("abort_pop", seen, 1'b1);
      repeat (40) @(negedge clk);
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      check("abort_tx_out", tx_out, 1'b1);
      check("abort_busy", tx_busy, 1'b0);
      check("abort_pop_low", tx_fifo_pop, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(negedge clk);
      check("abort_idle", tx_busy, 1'b0);
      check("abort_pops", rd_ptr - p0, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
